// File: rtl/mem_access_stage_if.sv
// Data-bus interface between the memory-access stage and the data memory.
// The stage is the master: it drives request, write enable, address, byte
// enables and lane-replicated store data; memory answers with ready/rdata.
interface mem_access_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ready, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage of the five-stage RISC-V pipeline.
// Owns the EX/MEM pipeline register, runs the data-bus handshake with a
// bounded wait, formats load data, resolves branches/jumps and produces the
// MEM/WB bundle, the EX/MEM forwarding value and the upstream stall.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (trap misaligned half/word
// accesses instead of silently aligning them).
module mem_access_stage #(
    parameter int DBUS_TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic [31:0]              ex_pc_i,
    input  logic [31:0]              ex_pc_plus_4_i,
    input  logic [31:0]              ex_result_i,
    input  logic [31:0]              ex_reg2_data_i,
    input  logic [31:0]              ex_immediate_i,
    input  logic                     ex_zero_flag_i,
    input  logic                     ex_mem_read_i,
    input  logic                     ex_mem_write_i,
    input  logic                     ex_branch_ctrl_i,
    input  logic                     ex_reg_write_i,
    input  logic [4:0]               ex_rd_addr_i,
    input  logic [2:0]               ex_funct3_i,
    input  logic [6:0]               ex_opcode_i,
    input  logic [1:0]               ex_mem_to_reg_i,
    mem_access_stage_if.master       dbus,
    output logic                     stall_o,
    output logic                     branch_taken_o,
    output logic [31:0]              branch_target_o,
    output logic [31:0]              fwd_data_o,
    output logic                     wb_valid_o,
    output logic                     wb_reg_write_o,
    output logic [4:0]               wb_rd_addr_o,
    output logic [1:0]               wb_mem_to_reg_o,
    output logic [31:0]              wb_alu_result_o,
    output logic [31:0]              wb_load_data_o,
    output logic [31:0]              wb_pc_plus_4_o,
    output logic                     bus_err_o,
    output logic                     misalign_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // EX/MEM pipeline register
    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_pcPlus4;
    logic [31:0] r_result;
    logic [31:0] r_reg2;
    logic [31:0] r_imm;
    logic        r_zero;
    logic        r_memRead;
    logic        r_memWrite;
    logic        r_branchCtrl;
    logic        r_regWrite;
    logic [4:0]  r_rd;
    logic [2:0]  r_funct3;
    logic [6:0]  r_opcode;
    logic [1:0]  r_memToReg;

    // Bus FSM
    logic [0:0]  r_state;
    logic [7:0]  r_waitCnt;

    logic        w_memOp;
    logic        w_misalign;
    logic [31:0] w_addr;
    logic        w_timeout;
    logic        w_req;
    logic        w_complete;
    logic        w_wbLoad;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_loadByte;
    logic [15:0] w_loadHalf;
    logic [31:0] w_loadData;
    logic        w_brCond;

    assign w_memOp = r_valid & (r_memRead | r_memWrite);

    // Access size decode: alignment check (trap build) or forced alignment
    always_comb begin
        w_misalign = 1'b0;
        w_addr     = r_result;
`ifdef MEM_MISALIGN_TRAP_EN
        if (r_funct3[1:0] == 2'b01) begin
            w_misalign = w_memOp & r_result[0];
        end else if (r_funct3[1:0] == 2'b10) begin
            w_misalign = w_memOp & (r_result[1:0] != 2'b00);
        end
`else
        if (r_funct3[1:0] == 2'b01) begin
            w_addr = {r_result[31:1], 1'b0};
        end else if (r_funct3[1:0] == 2'b10) begin
            w_addr = {r_result[31:2], 2'b00};
        end
`endif
    end

    assign w_timeout  = (r_state == S_WAIT) & (r_waitCnt == 8'(DBUS_TIMEOUT));
    assign w_req      = w_memOp & ~w_misalign & ~w_timeout;
    assign w_complete = w_req & dbus.ready;

    assign stall_o    = w_req & ~dbus.ready;
    assign bus_err_o  = w_timeout;
    assign misalign_o = w_misalign;

    // Byte enables and lane-replicated store data from size and address
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_reg2;
        case (r_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_addr[1:0];
                w_wdata = {4{r_reg2[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {w_addr[1], 1'b0};
                w_wdata = {2{r_reg2[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_reg2;
            end
        endcase
    end

    assign dbus.req   = w_req;
    assign dbus.we    = w_req & r_memWrite;
    assign dbus.addr  = w_req ? w_addr  : 32'd0;
    assign dbus.be    = w_req ? w_be    : 4'd0;
    assign dbus.wdata = w_req ? w_wdata : 32'd0;

    // Lane selection and sign/zero extension of load data
    always_comb begin
        case (w_addr[1:0])
            2'b00:   w_loadByte = dbus.rdata[7:0];
            2'b01:   w_loadByte = dbus.rdata[15:8];
            2'b10:   w_loadByte = dbus.rdata[23:16];
            default: w_loadByte = dbus.rdata[31:24];
        endcase
        w_loadHalf = w_addr[1] ? dbus.rdata[31:16] : dbus.rdata[15:0];
        case (r_funct3)
            3'b000:  w_loadData = {{24{w_loadByte[7]}}, w_loadByte};
            3'b001:  w_loadData = {{16{w_loadHalf[15]}}, w_loadHalf};
            3'b100:  w_loadData = {24'd0, w_loadByte};
            3'b101:  w_loadData = {16'd0, w_loadHalf};
            default: w_loadData = dbus.rdata;
        endcase
    end

    // Branch condition from the ALU flags; jumps are always taken
    always_comb begin
        case (r_funct3)
            3'b000:         w_brCond = r_zero;
            3'b001:         w_brCond = ~r_zero;
            3'b100, 3'b110: w_brCond = r_result[0];
            3'b101, 3'b111: w_brCond = ~r_result[0];
            default:        w_brCond = 1'b0;
        endcase
    end

    assign branch_taken_o  = r_valid & (((r_opcode == OP_BRANCH) & r_branchCtrl & w_brCond)
                                        | (r_opcode == OP_JAL) | (r_opcode == OP_JALR));
    assign branch_target_o = (r_opcode == OP_JALR) ? {r_result[31:1], 1'b0} : (r_pc + r_imm);
    assign fwd_data_o      = r_result;

    // EX/MEM register: hold while stalled, otherwise load (bubble on flush)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_pc         <= 32'd0;
            r_pcPlus4    <= 32'd0;
            r_result     <= 32'd0;
            r_reg2       <= 32'd0;
            r_imm        <= 32'd0;
            r_zero       <= 1'b0;
            r_memRead    <= 1'b0;
            r_memWrite   <= 1'b0;
            r_branchCtrl <= 1'b0;
            r_regWrite   <= 1'b0;
            r_rd         <= 5'd0;
            r_funct3     <= 3'd0;
            r_opcode     <= 7'd0;
            r_memToReg   <= 2'd0;
        end else if (!stall_o) begin
            r_valid      <= ~flush_i;
            r_pc         <= ex_pc_i;
            r_pcPlus4    <= ex_pc_plus_4_i;
            r_result     <= ex_result_i;
            r_reg2       <= ex_reg2_data_i;
            r_imm        <= ex_immediate_i;
            r_zero       <= ex_zero_flag_i;
            r_memRead    <= ex_mem_read_i    & ~flush_i;
            r_memWrite   <= ex_mem_write_i   & ~flush_i;
            r_branchCtrl <= ex_branch_ctrl_i & ~flush_i;
            r_regWrite   <= ex_reg_write_i   & ~flush_i;
            r_rd         <= ex_rd_addr_i;
            r_funct3     <= ex_funct3_i;
            r_opcode     <= ex_opcode_i;
            r_memToReg   <= flush_i ? 2'd0 : ex_mem_to_reg_i;
        end
    end

    // Bus FSM and wait counter; the first unanswered request cycle counts as one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_waitCnt <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req && !dbus.ready) begin
                        r_state   <= S_WAIT;
                        r_waitCnt <= 8'd1;
                    end
                end
                S_WAIT: begin
                    if (w_complete || w_timeout) begin
                        r_state   <= S_IDLE;
                        r_waitCnt <= 8'd0;
                    end else begin
                        r_waitCnt <= r_waitCnt + 8'd1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_waitCnt <= 8'd0;
                end
            endcase
        end
    end

    assign w_wbLoad = w_complete | (r_valid & ~w_memOp) | w_timeout | w_misalign;

    // MEM/WB register: retire finished instructions, bubble otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_o      <= 1'b0;
            wb_reg_write_o  <= 1'b0;
            wb_rd_addr_o    <= 5'd0;
            wb_mem_to_reg_o <= 2'd0;
            wb_alu_result_o <= 32'd0;
            wb_load_data_o  <= 32'd0;
            wb_pc_plus_4_o  <= 32'd0;
        end else if (w_wbLoad) begin
            wb_valid_o      <= 1'b1;
            wb_reg_write_o  <= r_regWrite & ~w_timeout & ~w_misalign;
            wb_rd_addr_o    <= r_rd;
            wb_mem_to_reg_o <= r_memToReg;
            wb_alu_result_o <= r_result;
            wb_load_data_o  <= w_complete ? w_loadData : 32'd0;
            wb_pc_plus_4_o  <= r_pcPlus4;
        end else begin
            wb_valid_o      <= 1'b0;
            wb_reg_write_o  <= 1'b0;
        end
    end

endmodule
